video_timing_gen_cfg: RTL and testbench
=======================================

# video_timing_gen_cfg

Runtime-reconfigurable video timing generator that succeeds the fixed 720p `video_sig_gen`. It produces pixel counters, sync, active-draw, new-frame and frame-count signals for the HDMI path, with timing programmable over a valid/ready config port and applied only on frame boundaries. A parametrised delay line supplies copies of sync, active-draw and new-frame that are aligned to the latency of the render and TMDS pipelines. It sits between the pixel clock and `render` / `tmds_encoder`.

## Interface
- H_BITS, 11, width of hcount and all horizontal timing fields
- V_BITS, 10, width of vcount and all vertical timing fields
- FC_BITS, 6, frame counter width
- SYNC_DELAY, 2, pipeline delay in cycles (0..15) for the `_d` outputs
- DEF_H_ACTIVE/H_FP/H_SYNC/H_BP, 1280/110/40/220, reset horizontal timing
- DEF_V_ACTIVE/V_FP/V_SYNC/V_BP, 720/5/5/20, reset vertical timing
- DEF_FC_MAX, 60, reset frame-count modulus
- clk_pixel_in  in  1  pixel clock; single clock domain
- rst_in  in  1  asynchronous, active-low reset
- cfg_valid_in  in  1  new timing offered
- cfg_ready_out  out  1  shadow register free
- cfg_h_active_in, cfg_h_fp_in, cfg_h_sync_in, cfg_h_bp_in  in  H_BITS each  horizontal fields
- cfg_v_active_in, cfg_v_fp_in, cfg_v_sync_in, cfg_v_bp_in  in  V_BITS each  vertical fields
- cfg_fc_max_in  in  FC_BITS  frame-count modulus
- cfg_err_out  out  1  one-cycle pulse: offered config rejected
- cfg_applied_out  out  1  one-cycle pulse: first pixel under new timing
- hcount_out  out  H_BITS  current pixel column
- vcount_out  out  V_BITS  current pixel row
- hs_out, vs_out, ad_out, nf_out  out  1 each  sync, active draw, new frame (aligned with counters)
- fc_out  out  FC_BITS  frame counter
- hs_d_out, vs_d_out, ad_d_out, nf_d_out  out  1 each  same signals delayed SYNC_DELAY cycles

## Operation
- H_TOT = active+fp+sync+bp. Compute it in H_BITS+2 bits; compute V_TOT the same way in V_BITS+2 bits.
- Each cycle, hcount increments. When hcount = H_TOT-1, it wraps to 0 and vcount increments. When vcount = V_TOT-1 and hcount wraps, vcount also wraps to 0. The move to (0,0) is the frame boundary.
- All flags are registered and describe the (hcount, vcount) presented in the same cycle:
  - ad = hcount<H_ACTIVE && vcount<V_ACTIVE
  - hs = hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs = vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
  - All syncs are active-high.
- nf = 1 for exactly one cycle, at hcount=H_ACTIVE, vcount=V_ACTIVE.
- fc increments in the nf cycle. It wraps from FC_MAX-1 to 0.
- Config port states:
  - IDLE (ready=1): cfg_valid_in && ready accepts the offer.
  - Validation on accept: reject if any active, sync or fc_max field is 0, or if H_TOT ≥ 2^H_BITS or V_TOT ≥ 2^V_BITS. A rejected offer pulses cfg_err_out the next cycle and stays in IDLE.
  - A valid offer is latched into the shadow register; go to PENDING (ready=0).
  - PENDING: on the frame boundary, the live timing takes the shadow value, fc resets to 0, cfg_applied_out pulses alongside pixel (0,0), and the state returns to IDLE.
- Delay line: a SYNC_DELAY-deep shift register carries {hs, vs, ad, nf}. With SYNC_DELAY=0, the `_d` outputs equal the undelayed outputs.

## Timing
- Reset (async assert):
  - hcount = DEF H_TOT-1, vcount = DEF V_TOT-1 (last blanking pixel).
  - hs, vs, ad, nf, fc, cfg_err, cfg_applied and the delay line all = 0; cfg_ready = 1.
  - Live and shadow timing load the DEF_* values.
- First edge after release presents (0,0) with ad=1.
- Counter-to-flag latency: 0 (same cycle). `_d` outputs lag by exactly SYNC_DELAY cycles.
- Accept on the same cycle as the boundary: that boundary uses the old timing, and the new timing applies at the next boundary.
- cfg_ready rises on the cycle after cfg_applied.
- A new config is applied atomically; no partial-frame mixing of old and new fields.
- Reset asserted mid-frame or mid-PENDING: the pending config is discarded and the defaults are restored.

## Test plan
- Reset release, defaults → (0,0) with ad=1 on the first edge. hs high for hcount 1390..1429. vs high for vcount 725..729. nf at (1280,720). Frame length 1650×750 cycles.
- 60 frames → fc_out goes 0..59 then back to 0. nf pulses once per frame.
- Offer 640/16/96/48, 480/10/2/33, fc_max 30 mid-frame → ready drops. Current frame completes at 1650×750. cfg_applied pulses at (0,0). Next frame is 800×525 and fc restarts at 0.
- Offer with h_sync=0, then a second offer with H sum 2100 → cfg_err_out pulses each time. Timing is unchanged and ready stays 1.
- SYNC_DELAY=3 → hs_d/vs_d/ad_d/nf_d equal hs/vs/ad/nf shifted exactly 3 cycles. After reset, the first 3 `_d` samples are 0.
- rst_in low mid-PENDING → counters go to (1649,749) asynchronously. After release, 720p timing runs and no cfg_applied pulse occurs.

Source files
------------

// File: rtl/video_timing_gen_cfg.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_cfg
// Description : Runtime-reconfigurable video timing generator. Produces pixel
//               counters, active-high syncs, active-draw, new-frame and a
//               frame counter. New timing arrives over a valid/ready port,
//               is checked, held in a shadow register and applied only on a
//               frame boundary. A SYNC_DELAY-deep shift register provides
//               copies of hs/vs/ad/nf aligned to downstream pipeline latency.
// Ports       : clk_pixel_in / rst_in (async, active-low)
//               cfg_*_in, cfg_valid_in, cfg_ready_out  - config handshake
//               cfg_err_out, cfg_applied_out           - one-cycle pulses
//               hcount_out, vcount_out, hs/vs/ad/nf_out, fc_out
//               hs/vs/ad/nf_d_out                      - delayed flags
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen_cfg #(
    parameter int H_BITS       = 11,
    parameter int V_BITS       = 10,
    parameter int FC_BITS      = 6,
    parameter int SYNC_DELAY   = 2,
    parameter int DEF_H_ACTIVE = 1280,
    parameter int DEF_H_FP     = 110,
    parameter int DEF_H_SYNC   = 40,
    parameter int DEF_H_BP     = 220,
    parameter int DEF_V_ACTIVE = 720,
    parameter int DEF_V_FP     = 5,
    parameter int DEF_V_SYNC   = 5,
    parameter int DEF_V_BP     = 20,
    parameter int DEF_FC_MAX   = 60
) (
    input  logic               clk_pixel_in,
    input  logic               rst_in,
    input  logic               cfg_valid_in,
    output logic               cfg_ready_out,
    input  logic [H_BITS-1:0]  cfg_h_active_in,
    input  logic [H_BITS-1:0]  cfg_h_fp_in,
    input  logic [H_BITS-1:0]  cfg_h_sync_in,
    input  logic [H_BITS-1:0]  cfg_h_bp_in,
    input  logic [V_BITS-1:0]  cfg_v_active_in,
    input  logic [V_BITS-1:0]  cfg_v_fp_in,
    input  logic [V_BITS-1:0]  cfg_v_sync_in,
    input  logic [V_BITS-1:0]  cfg_v_bp_in,
    input  logic [FC_BITS-1:0] cfg_fc_max_in,
    output logic               cfg_err_out,
    output logic               cfg_applied_out,
    output logic [H_BITS-1:0]  hcount_out,
    output logic [V_BITS-1:0]  vcount_out,
    output logic               hs_out,
    output logic               vs_out,
    output logic               ad_out,
    output logic               nf_out,
    output logic [FC_BITS-1:0] fc_out,
    output logic               hs_d_out,
    output logic               vs_d_out,
    output logic               ad_d_out,
    output logic               nf_d_out
);

    localparam int HT_BITS = H_BITS + 2;
    localparam int VT_BITS = V_BITS + 2;

    typedef struct packed {
        logic [H_BITS-1:0]  h_active;
        logic [H_BITS-1:0]  h_fp;
        logic [H_BITS-1:0]  h_sync;
        logic [H_BITS-1:0]  h_bp;
        logic [V_BITS-1:0]  v_active;
        logic [V_BITS-1:0]  v_fp;
        logic [V_BITS-1:0]  v_sync;
        logic [V_BITS-1:0]  v_bp;
        logic [FC_BITS-1:0] fc_max;
    } timing_t;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } cfg_state_t;

    localparam timing_t c_DEF_TIMING = '{
        h_active: H_BITS'(DEF_H_ACTIVE), h_fp: H_BITS'(DEF_H_FP),
        h_sync:   H_BITS'(DEF_H_SYNC),   h_bp: H_BITS'(DEF_H_BP),
        v_active: V_BITS'(DEF_V_ACTIVE), v_fp: V_BITS'(DEF_V_FP),
        v_sync:   V_BITS'(DEF_V_SYNC),   v_bp: V_BITS'(DEF_V_BP),
        fc_max:   FC_BITS'(DEF_FC_MAX)
    };

    // Reset parks the counters on the last blanking pixel so the first
    // clock edge after release lands on (0,0).
    localparam logic [H_BITS-1:0] c_DEF_H_LAST =
        H_BITS'(DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP - 1);
    localparam logic [V_BITS-1:0] c_DEF_V_LAST =
        V_BITS'(DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP - 1);

    function automatic logic [HT_BITS-1:0] h_total(input timing_t t);
        return HT_BITS'(t.h_active) + HT_BITS'(t.h_fp)
             + HT_BITS'(t.h_sync)   + HT_BITS'(t.h_bp);
    endfunction

    function automatic logic [VT_BITS-1:0] v_total(input timing_t t);
        return VT_BITS'(t.v_active) + VT_BITS'(t.v_fp)
             + VT_BITS'(t.v_sync)   + VT_BITS'(t.v_bp);
    endfunction

    cfg_state_t         r_state, w_state_next;
    timing_t            r_live, r_shadow, w_offer;
    logic [H_BITS-1:0]  r_hcount, w_hcount_nxt;
    logic [V_BITS-1:0]  r_vcount, w_vcount_nxt;
    logic               r_hs, r_vs, r_ad, r_nf;
    logic [FC_BITS-1:0] r_fc;
    logic               r_cfg_err, r_cfg_applied;
    logic               w_shadow_load, w_err_nxt, w_apply, w_accept, w_offer_bad;
    logic               w_h_last, w_v_last, w_boundary;
    logic               w_hs_nxt, w_vs_nxt, w_ad_nxt, w_nf_nxt;
    logic [HT_BITS-1:0] w_h_tot, w_off_h_tot, w_hs_start, w_hn_ext;
    logic [VT_BITS-1:0] w_v_tot, w_off_v_tot, w_vs_start, w_vn_ext;
    logic [H_BITS-1:0]  w_e_h_active, w_e_h_fp, w_e_h_sync;
    logic [V_BITS-1:0]  w_e_v_active, w_e_v_fp, w_e_v_sync;

    assign w_offer = '{
        h_active: cfg_h_active_in, h_fp: cfg_h_fp_in,
        h_sync:   cfg_h_sync_in,   h_bp: cfg_h_bp_in,
        v_active: cfg_v_active_in, v_fp: cfg_v_fp_in,
        v_sync:   cfg_v_sync_in,   v_bp: cfg_v_bp_in,
        fc_max:   cfg_fc_max_in
    };

    assign w_off_h_tot = h_total(w_offer);
    assign w_off_v_tot = v_total(w_offer);
    assign w_offer_bad = (cfg_h_active_in == '0) || (cfg_h_sync_in == '0)
                      || (cfg_v_active_in == '0) || (cfg_v_sync_in == '0)
                      || (cfg_fc_max_in == '0)
                      || (w_off_h_tot >= HT_BITS'(1 << H_BITS))
                      || (w_off_v_tot >= VT_BITS'(1 << V_BITS));

    // Ready stays low through the cfg_applied cycle.
    assign cfg_ready_out = (r_state == S_IDLE) && !r_cfg_applied;
    assign w_accept      = cfg_valid_in && cfg_ready_out;

    assign w_h_tot    = h_total(r_live);
    assign w_v_tot    = v_total(r_live);
    assign w_h_last   = ({2'b00, r_hcount} == (w_h_tot - HT_BITS'(1)));
    assign w_v_last   = ({2'b00, r_vcount} == (w_v_tot - VT_BITS'(1)));
    assign w_boundary = w_h_last && w_v_last;

    assign w_hcount_nxt = w_h_last ? '0 : r_hcount + H_BITS'(1);
    assign w_vcount_nxt = !w_h_last ? r_vcount :
                          (w_v_last ? '0 : r_vcount + V_BITS'(1));

    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_shadow_load = 1'b0;
        w_err_nxt     = 1'b0;
        w_apply       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_offer_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_shadow_load = 1'b1;
                        w_state_next  = S_PENDING;
                    end
                end
            end
            S_PENDING: begin
                if (w_boundary) begin
                    w_apply      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Flags are computed for the pixel about to be presented, so at an apply
    // boundary they must already use the shadow timing.
    assign w_e_h_active = w_apply ? r_shadow.h_active : r_live.h_active;
    assign w_e_h_fp     = w_apply ? r_shadow.h_fp     : r_live.h_fp;
    assign w_e_h_sync   = w_apply ? r_shadow.h_sync   : r_live.h_sync;
    assign w_e_v_active = w_apply ? r_shadow.v_active : r_live.v_active;
    assign w_e_v_fp     = w_apply ? r_shadow.v_fp     : r_live.v_fp;
    assign w_e_v_sync   = w_apply ? r_shadow.v_sync   : r_live.v_sync;

    assign w_hn_ext   = {2'b00, w_hcount_nxt};
    assign w_vn_ext   = {2'b00, w_vcount_nxt};
    assign w_hs_start = HT_BITS'(w_e_h_active) + HT_BITS'(w_e_h_fp);
    assign w_vs_start = VT_BITS'(w_e_v_active) + VT_BITS'(w_e_v_fp);
    assign w_hs_nxt   = (w_hn_ext >= w_hs_start)
                     && (w_hn_ext < (w_hs_start + HT_BITS'(w_e_h_sync)));
    assign w_vs_nxt   = (w_vn_ext >= w_vs_start)
                     && (w_vn_ext < (w_vs_start + VT_BITS'(w_e_v_sync)));
    assign w_ad_nxt   = (w_hcount_nxt < w_e_h_active) && (w_vcount_nxt < w_e_v_active);
    assign w_nf_nxt   = (w_hcount_nxt == w_e_h_active) && (w_vcount_nxt == w_e_v_active);

    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            r_live        <= c_DEF_TIMING;
            r_shadow      <= c_DEF_TIMING;
            r_hcount      <= c_DEF_H_LAST;
            r_vcount      <= c_DEF_V_LAST;
            r_hs          <= 1'b0;
            r_vs          <= 1'b0;
            r_ad          <= 1'b0;
            r_nf          <= 1'b0;
            r_fc          <= '0;
            r_cfg_err     <= 1'b0;
            r_cfg_applied <= 1'b0;
        end else begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hs          <= w_hs_nxt;
            r_vs          <= w_vs_nxt;
            r_ad          <= w_ad_nxt;
            r_nf          <= w_nf_nxt;
            r_cfg_err     <= w_err_nxt;
            r_cfg_applied <= w_apply;
            if (w_apply)       r_live   <= r_shadow;
            if (w_shadow_load) r_shadow <= w_offer;
            // nf never coincides with (0,0) since active sizes are non-zero,
            // so the live fc_max is the right modulus here.
            if (w_apply) begin
                r_fc <= '0;
            end else if (w_nf_nxt) begin
                r_fc <= (r_fc >= (r_live.fc_max - FC_BITS'(1))) ? '0 : r_fc + FC_BITS'(1);
            end
        end
    end

    assign hcount_out      = r_hcount;
    assign vcount_out      = r_vcount;
    assign hs_out          = r_hs;
    assign vs_out          = r_vs;
    assign ad_out          = r_ad;
    assign nf_out          = r_nf;
    assign fc_out          = r_fc;
    assign cfg_err_out     = r_cfg_err;
    assign cfg_applied_out = r_cfg_applied;

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign {hs_d_out, vs_d_out, ad_d_out, nf_d_out} = {r_hs, r_vs, r_ad, r_nf};
        end else begin : g_delay
            logic [3:0] r_pipe [SYNC_DELAY];
            always_ff @(posedge clk_pixel_in or negedge rst_in) begin
                if (!rst_in) begin
                    for (int i = 0; i < SYNC_DELAY; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= {r_hs, r_vs, r_ad, r_nf};
                    for (int i = 1; i < SYNC_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign {hs_d_out, vs_d_out, ad_d_out, nf_d_out} = r_pipe[SYNC_DELAY-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen_cfg
// Description : Self-checking bench for video_timing_gen_cfg. A pixel-index
//               model predicts every output each cycle; directed phases pin
//               the model with hand-computed literals. Small default timing
//               (15x8 pixels, fc modulus 4) keeps frames short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen_cfg;

    localparam int H_BITS = 11, V_BITS = 10, FC_BITS = 6, SYNC_DELAY = 3;
    localparam int D_HA = 8, D_HF = 2, D_HS = 3, D_HB = 2;   // 15 columns
    localparam int D_VA = 4, D_VF = 1, D_VS = 2, D_VB = 1;   // 8 rows
    localparam int D_FC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic cfg_valid = 1'b0;
    logic [H_BITS-1:0] c_ha = '0, c_hf = '0, c_hs = '0, c_hb = '0;
    logic [V_BITS-1:0] c_va = '0, c_vf = '0, c_vs = '0, c_vb = '0;
    logic [FC_BITS-1:0] c_fm = '0;
    logic cfg_ready, cfg_err, cfg_applied;
    logic [H_BITS-1:0] hcount;
    logic [V_BITS-1:0] vcount;
    logic hs, vs, ad, nf, hs_d, vs_d, ad_d, nf_d;
    logic [FC_BITS-1:0] fc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    video_timing_gen_cfg #(
        .H_BITS(H_BITS), .V_BITS(V_BITS), .FC_BITS(FC_BITS), .SYNC_DELAY(SYNC_DELAY),
        .DEF_H_ACTIVE(D_HA), .DEF_H_FP(D_HF), .DEF_H_SYNC(D_HS), .DEF_H_BP(D_HB),
        .DEF_V_ACTIVE(D_VA), .DEF_V_FP(D_VF), .DEF_V_SYNC(D_VS), .DEF_V_BP(D_VB),
        .DEF_FC_MAX(D_FC)
    ) dut (
        .clk_pixel_in(clk), .rst_in(rst_n),
        .cfg_valid_in(cfg_valid), .cfg_ready_out(cfg_ready),
        .cfg_h_active_in(c_ha), .cfg_h_fp_in(c_hf), .cfg_h_sync_in(c_hs), .cfg_h_bp_in(c_hb),
        .cfg_v_active_in(c_va), .cfg_v_fp_in(c_vf), .cfg_v_sync_in(c_vs), .cfg_v_bp_in(c_vb),
        .cfg_fc_max_in(c_fm), .cfg_err_out(cfg_err), .cfg_applied_out(cfg_applied),
        .hcount_out(hcount), .vcount_out(vcount),
        .hs_out(hs), .vs_out(vs), .ad_out(ad), .nf_out(nf), .fc_out(fc),
        .hs_d_out(hs_d), .vs_d_out(vs_d), .ad_d_out(ad_d), .nf_d_out(nf_d)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (pixel index within frame) --------
    typedef struct { int ha, hf, hs, hb, va, vf, vs, vb, fm; } tmg_t;
    localparam tmg_t DEF_T = '{D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, D_FC};

    function automatic int htot(input tmg_t x); return x.ha + x.hf + x.hs + x.hb; endfunction
    function automatic int vtot(input tmg_t x); return x.va + x.vf + x.vs + x.vb; endfunction

    tmg_t m_live, m_shadow, m_off;
    int   m_t, m_h, m_v, m_fc;
    bit   m_pend, m_applied, m_err, m_hs, m_vs, m_ad, m_nf, m_acc, m_bad;
    logic [3:0] m_hist [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_live = DEF_T; m_shadow = DEF_T;
            m_t = htot(DEF_T) * vtot(DEF_T) - 1;
            m_h = m_t % htot(DEF_T); m_v = m_t / htot(DEF_T);
            m_fc = 0; m_pend = 0; m_applied = 0; m_err = 0;
            {m_hs, m_vs, m_ad, m_nf} = 4'b0;
            for (int i = 0; i < 3; i++) m_hist[i] = 4'b0;
        end else begin
            m_acc = cfg_valid && !m_pend && !m_applied;
            m_off = '{int'(c_ha), int'(c_hf), int'(c_hs), int'(c_hb),
                      int'(c_va), int'(c_vf), int'(c_vs), int'(c_vb), int'(c_fm)};
            m_bad = (m_off.ha == 0) || (m_off.hs == 0) || (m_off.va == 0) || (m_off.vs == 0)
                 || (m_off.fm == 0) || (htot(m_off) >= (1 << H_BITS))
                 || (vtot(m_off) >= (1 << V_BITS));
            m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0];
            m_hist[0] = {m_hs, m_vs, m_ad, m_nf};
            m_applied = 0;
            if (m_t == htot(m_live) * vtot(m_live) - 1) begin
                m_t = 0;
                if (m_pend) begin
                    m_live = m_shadow; m_pend = 0; m_fc = 0; m_applied = 1;
                end
            end else begin
                m_t++;
            end
            m_h  = m_t % htot(m_live);
            m_v  = m_t / htot(m_live);
            m_ad = (m_h < m_live.ha) && (m_v < m_live.va);
            m_hs = (m_h >= m_live.ha + m_live.hf) && (m_h < m_live.ha + m_live.hf + m_live.hs);
            m_vs = (m_v >= m_live.va + m_live.vf) && (m_v < m_live.va + m_live.vf + m_live.vs);
            m_nf = (m_h == m_live.ha) && (m_v == m_live.va);
            if (m_nf) m_fc = (m_fc + 1) % m_live.fm;
            m_err = m_acc && m_bad;
            if (m_acc && !m_bad) begin m_shadow = m_off; m_pend = 1; end
        end
    end

    always @(negedge clk) begin
        chk("hcount",  hcount, m_h);
        chk("vcount",  vcount, m_v);
        chk("hs",      hs, m_hs);
        chk("vs",      vs, m_vs);
        chk("ad",      ad, m_ad);
        chk("nf",      nf, m_nf);
        chk("fc",      fc, m_fc);
        chk("ready",   cfg_ready, !m_pend && !m_applied);
        chk("err",     cfg_err, m_err);
        chk("applied", cfg_applied, m_applied);
        chk("hs_d",    hs_d, m_hist[2][3]);
        chk("vs_d",    vs_d, m_hist[2][2]);
        chk("ad_d",    ad_d, m_hist[2][1]);
        chk("nf_d",    nf_d, m_hist[2][0]);
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic offer(input int ha, hf, hs_, hb, va, vf, vs_, vb, fm);
        c_ha = H_BITS'(ha); c_hf = H_BITS'(hf); c_hs = H_BITS'(hs_); c_hb = H_BITS'(hb);
        c_va = V_BITS'(va); c_vf = V_BITS'(vf); c_vs = V_BITS'(vs_); c_vb = V_BITS'(vb);
        c_fm = FC_BITS'(fm);
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_applied(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!cfg_applied && n < 300);
        chk({name, "_seen"}, cfg_applied, 1);
        chk({name, "_h0"}, hcount, 0);
        chk({name, "_v0"}, vcount, 0);
        chk({name, "_fc0"}, fc, 0);
    endtask

    task automatic frame_len(input string name, input int exp);
        int n;
        @(negedge clk);
        chk({name, "_ready_after_applied"}, cfg_ready, 1);
        n = 1;
        do begin @(negedge clk); n++; end while (!(hcount == 0 && vcount == 0) && n < 400);
        chk(name, n, exp);
    endtask

    initial begin
        int nf_cnt, nf_first, nf_prev, app_cnt, n;
        int fc_exp [5] = '{1, 2, 3, 0, 1};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hcount", hcount, 14);
        chk("rst_vcount", vcount, 7);
        chk("rst_ready", cfg_ready, 1);
        rst_n = 1'b1;

        // Default timing: 5 frames of 120 cycles, index 0 is pixel (0,0).
        nf_cnt = 0; nf_first = -1; nf_prev = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (i == 0) begin chk("first_h", hcount, 0); chk("first_v", vcount, 0); chk("first_ad", ad, 1); end
            if (i < 3)  chk("early_ad_d", ad_d, 0);
            if (i == 3) chk("ad_d_lag3", ad_d, 1);
            if (i == 9)   chk("hs_idx9", hs, 0);
            if (i == 10)  chk("hs_idx10", hs, 1);
            if (i == 12)  chk("hs_idx12", hs, 1);
            if (i == 13)  chk("hs_idx13", hs, 0);
            if (i == 7)   chk("ad_idx7", ad, 1);
            if (i == 8)   chk("ad_idx8", ad, 0);
            if (i == 74)  chk("vs_idx74", vs, 0);
            if (i == 75)  chk("vs_idx75", vs, 1);
            if (i == 104) chk("vs_idx104", vs, 1);
            if (i == 105) chk("vs_idx105", vs, 0);
            if (nf) begin
                if (nf_cnt == 0) begin
                    nf_first = i;
                    chk("nf_h", hcount, 8);
                    chk("nf_v", vcount, 4);
                end else begin
                    chk("nf_period", i - nf_prev, 120);
                end
                if (nf_cnt < 5) chk("fc_seq", fc, fc_exp[nf_cnt]);
                nf_prev = i;
                nf_cnt++;
            end
        end
        chk("nf_first_idx", nf_first, 68);
        chk("nf_count", nf_cnt, 5);

        // Rejected offers: zero h_sync, then horizontal total 2100.
        @(posedge clk); #1;
        offer(8, 2, 0, 2, 4, 1, 2, 1, 4);
        @(negedge clk);
        chk("err_zero_sync", cfg_err, 1);
        chk("err_zero_ready", cfg_ready, 1);
        @(posedge clk); #1;
        offer(2000, 50, 30, 20, 4, 1, 2, 1, 4);
        @(negedge clk);
        chk("err_htot", cfg_err, 1);
        chk("err_htot_ready", cfg_ready, 1);
        @(negedge clk);
        chk("err_one_cycle", cfg_err, 0);

        // Valid offer mid-frame: 11x7 frame, fc modulus 3.
        repeat (20) @(posedge clk); #1;
        offer(5, 1, 2, 3, 3, 1, 1, 2, 3);
        @(negedge clk);
        chk("pending_ready", cfg_ready, 0);
        wait_applied("apply1");
        frame_len("frame_len_11x7", 77);

        // Offer accepted in the last pixel of a frame: that boundary keeps
        // the old timing, the following one switches to 12x7.
        n = 0;
        do begin @(negedge clk); n++; end while (!(hcount == 10 && vcount == 6) && n < 200);
        chk("reach_last_pixel", (hcount == 10 && vcount == 6), 1);
        offer(6, 2, 2, 2, 4, 1, 1, 1, 5);
        @(negedge clk);
        chk("bnd_no_apply", cfg_applied, 0);
        chk("bnd_h0", hcount, 0);
        chk("bnd_ready", cfg_ready, 0);
        wait_applied("apply2");
        frame_len("frame_len_12x7", 84);

        // Reset while a config is pending: defaults return, nothing applies.
        @(posedge clk); #1;
        offer(4, 1, 1, 1, 3, 1, 1, 1, 2);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_h", hcount, 14);
        chk("async_rst_v", vcount, 7);
        chk("async_rst_ready", cfg_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        app_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 120) begin chk("rst2_h", hcount, 0); chk("rst2_v", vcount, 0); end
            if (cfg_applied) app_cnt++;
        end
        chk("no_apply_after_rst", app_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
